// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with a 32-entry destination scoreboard and a registered valid/ready output.
// Optional macro ID_WB_BYPASS_EN: forward wb_dat into operands and suppress that hazard in the same cycle.
`timescale 1ns/1ps
module id_stage #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [D_WIDTH-1:0] in_pc,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  input  logic [D_WIDTH-1:0] rs1Dat,
  input  logic [D_WIDTH-1:0] rs2Dat,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic [D_WIDTH-1:0] wb_dat,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_pc,
  output logic [D_WIDTH-1:0] out_op1,
  output logic [D_WIDTH-1:0] out_op2,
  output logic [D_WIDTH-1:0] out_imm,
  output logic [4:0]         out_rd,
  output logic [6:0]         out_opcode,
  output logic [2:0]         out_funct3,
  output logic               out_f7b,
  output logic               out_wb_en,
  output logic               out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]         w_opcode;
  logic [4:0]         w_rd;
  logic               w_known;
  logic               w_uses_rs1;
  logic               w_uses_rs2;
  logic               w_no_wb;
  logic               w_wb_en;
  logic [31:0]        w_imm32;
  logic [D_WIDTH-1:0] w_imm;
  logic               w_byp1;
  logic               w_byp2;
  logic [D_WIDTH-1:0] w_op1;
  logic [D_WIDTH-1:0] w_op2;
  logic               w_hazard;
  logic               w_accept;
  logic [31:0]        w_busy_nxt;

  logic [31:0]        r_busy;
  logic               r_out_valid;
  logic [D_WIDTH-1:0] r_pc;
  logic [D_WIDTH-1:0] r_op1;
  logic [D_WIDTH-1:0] r_op2;
  logic [D_WIDTH-1:0] r_imm;
  logic [4:0]         r_rd;
  logic [6:0]         r_opcode;
  logic [2:0]         r_funct3;
  logic               r_f7b;
  logic               r_wb_en;
  logic               r_illegal;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];

  always_comb begin
    w_known    = 1'b1;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    w_no_wb    = 1'b0;
    w_imm32    = '0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_uses_rs1 = 1'b0;
        w_imm32    = {in_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        w_uses_rs1 = 1'b0;
        w_imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_BRANCH: begin
        w_uses_rs2 = 1'b1;
        w_no_wb    = 1'b1;
        w_imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OPC_STORE: begin
        w_uses_rs2 = 1'b1;
        w_no_wb    = 1'b1;
        w_imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_OP: begin
        w_uses_rs2 = 1'b1;
      end
      default: begin
        // Unknown opcodes flow through as illegal with no register usage.
        w_known    = 1'b0;
        w_uses_rs1 = 1'b0;
      end
    endcase
  end

  assign w_wb_en = w_known && !w_no_wb && (w_rd != 5'd0);
  assign w_imm   = D_WIDTH'($signed(w_imm32));

`ifdef ID_WB_BYPASS_EN
  assign w_byp1 = wb_valid && (wb_rd == rs1) && (rs1 != 5'd0);
  assign w_byp2 = wb_valid && (wb_rd == rs2) && (rs2 != 5'd0);
`else
  logic w_unused_wb_dat;
  assign w_unused_wb_dat = ^wb_dat;
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_op1 = w_byp1 ? wb_dat : rs1Dat;
  assign w_op2 = w_byp2 ? wb_dat : rs2Dat;

  assign w_hazard = (w_uses_rs1 && r_busy[rs1] && !w_byp1) ||
                    (w_uses_rs2 && r_busy[rs2] && !w_byp2);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and the output payload holds while out_valid && !out_ready.
  assign in_ready = !w_hazard && !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Set beats clear on the same index; both clear sources simply clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush && r_out_valid && r_wb_en) w_busy_nxt[r_rd] = 1'b0;
    if (wb_valid) w_busy_nxt[wb_rd] = 1'b0;
    if (w_accept && w_wb_en) w_busy_nxt[w_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_opcode    <= '0;
      r_funct3    <= '0;
      r_f7b       <= 1'b0;
      r_wb_en     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_pc        <= in_pc;
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_imm       <= w_imm;
        r_rd        <= w_rd;
        r_opcode    <= w_opcode;
        r_funct3    <= in_instr[14:12];
        r_f7b       <= in_instr[30];
        r_wb_en     <= w_wb_en;
        r_illegal   <= !w_known;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_pc;
  assign out_op1     = r_op1;
  assign out_op2     = r_op2;
  assign out_imm     = r_imm;
  assign out_rd      = r_rd;
  assign out_opcode  = r_opcode;
  assign out_funct3  = r_funct3;
  assign out_f7b     = r_f7b;
  assign out_wb_en   = r_wb_en;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: vector table, directed multi-cycle sequences and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_id_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic [W-1:0] in_pc;
  logic [4:0]   rs1, rs2;
  logic [W-1:0] rs1Dat, rs2Dat;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_dat;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_pc, out_op1, out_op2, out_imm;
  logic [4:0]   out_rd;
  logic [6:0]   out_opcode;
  logic [2:0]   out_funct3;
  logic         out_f7b, out_wb_en, out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage #(.D_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1(rs1), .rs2(rs2), .rs1Dat(rs1Dat), .rs2Dat(rs2Dat),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_dat(wb_dat), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_f7b(out_f7b),
    .out_wb_en(out_wb_en), .out_illegal(out_illegal)
  );

  // Register file stand-in: written at the retirement edge, read combinationally.
  logic [W-1:0] rf [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? '0 : 32'(i) * 32'h01010101 + 32'h100;
    end else if (wb_valid && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_dat;
    end
  end
  assign rs1Dat = rf[rs1];
  assign rs2Dat = rf[rs2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [4:0] rd, input logic [31:0] dat);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_dat   = dat;
    tick();
    wb_valid = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [31:0] imm;
    logic        u1;
    logic        u2;
    logic        wb;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b, wb, ill;
  } out_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    logic [6:0]  opc;
    logic [12:0] b;
    logic [20:0] j;
    logic signed [31:0] s;
    d   = '0;
    opc = ins[6:0];
    s   = $signed(ins);
    b   = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (opc)
      7'b0110111, 7'b0010111: d.imm = ins & 32'hFFFFF000;
      7'b1101111: d.imm = 32'($signed(j));
      7'b1100111, 7'b0000011, 7'b0010011: begin d.u1 = 1'b1; d.imm = 32'(s >>> 20); end
      7'b1100011: begin d.u1 = 1'b1; d.u2 = 1'b1; d.imm = 32'($signed(b)); end
      7'b0100011: begin
        d.u1 = 1'b1; d.u2 = 1'b1;
        d.imm = (32'(s >>> 20) & 32'hFFFFFFE0) | {27'b0, ins[11:7]};
      end
      7'b0110011: begin d.u1 = 1'b1; d.u2 = 1'b1; end
      default: d.ill = 1'b1;
    endcase
    d.wb = !d.ill && (opc != 7'b1100011) && (opc != 7'b0100011) && (ins[11:7] != 5'd0);
    return d;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  opcs [12];
    logic [31:0] ins;
    opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
             7'b0100011, 7'b0010011, 7'b0110011, 7'h7F, 7'b0001111, 7'b1110011};
    ins = $urandom;
    ins[6:0]   = opcs[$urandom_range(0, 11)];
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  task automatic chk_out(input out_t m);
    chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, m.v});
    if (m.v) begin
      chk("rnd_out_pc", out_pc, m.pc);
      chk("rnd_out_op1", out_op1, m.op1);
      chk("rnd_out_op2", out_op2, m.op2);
      chk("rnd_out_imm", out_imm, m.imm);
      chk("rnd_out_rd", {27'b0, out_rd}, {27'b0, m.rd});
      chk("rnd_out_ctl", {19'b0, out_opcode, out_funct3, out_f7b, out_wb_en, out_illegal},
                         {19'b0, m.opc, m.f3, m.f7b, m.wb, m.ill});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] e1, e2, sav_dat;
  logic [4:0]  issued_q [$];
  out_t        m_out;
  logic [31:0] m_busy, nb;
  dec_t        d;
  logic [4:0]  r1, r2;
  logic        byp1, byp2, haz, rdy;

  initial begin
    vecs[0]  = '{32'h00500093, 32'h00000005, 5'd1,  1'b1, 1'b0}; // ADDI x1,x0,5
    vecs[1]  = '{32'hFE312E23, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0}; // SW x3,-4(x2)
    vecs[2]  = '{32'h01CE00B3, 32'h00000000, 5'd1,  1'b1, 1'b0}; // ADD x1,x28,x28
    vecs[3]  = '{32'h123452B7, 32'h12345000, 5'd5,  1'b1, 1'b0}; // LUI x5
    vecs[4]  = '{32'h001000EF, 32'h00000800, 5'd1,  1'b1, 1'b0}; // JAL x1,+2048
    vecs[5]  = '{32'hFE208EE3, 32'hFFFFFFFC, 5'd29, 1'b0, 1'b0}; // BEQ x1,x2,-4
    vecs[6]  = '{32'hFFFFF397, 32'hFFFFF000, 5'd7,  1'b1, 1'b0}; // AUIPC x7
    vecs[7]  = '{32'h01008067, 32'h00000010, 5'd0,  1'b0, 1'b0}; // JALR x0,16(x1)
    vecs[8]  = '{32'h0000007F, 32'h00000000, 5'd0,  1'b0, 1'b1}; // illegal
    vecs[9]  = '{32'h00108133, 32'h00000000, 5'd2,  1'b1, 1'b0}; // ADD x2,x1,x1
    vecs[10] = '{32'hFFF02203, 32'hFFFFFFFF, 5'd4,  1'b1, 1'b0}; // LW x4,-1(x0)

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; wb_valid = 1'b0;
    wb_rd = '0; wb_dat = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_out_ctl", {19'b0, out_opcode, out_funct3, out_f7b, out_wb_en, out_illegal}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // Table: each vector issued from an idle pipe, then its destination retired.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(i) * 4;
      #1;
      e1 = rf[vecs[i].instr[19:15]];
      e2 = rf[vecs[i].instr[24:20]];
      chk("vec_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("vec_out_valid", {31'b0, out_valid}, 32'd1);
      chk("vec_out_imm", out_imm, vecs[i].imm);
      chk("vec_out_rd", {27'b0, out_rd}, {27'b0, vecs[i].rd});
      chk("vec_out_wb_en", {31'b0, out_wb_en}, {31'b0, vecs[i].wb});
      chk("vec_out_illegal", {31'b0, out_illegal}, {31'b0, vecs[i].ill});
      chk("vec_out_op1", out_op1, e1);
      chk("vec_out_op2", out_op2, e2);
      chk("vec_out_pc", out_pc, 32'h1000 + 32'(i) * 4);
      if (vecs[i].wb) retire(vecs[i].rd, $urandom);
      else tick();
    end

    // RAW hazard: ADDI x1 then ADD x2,x1,x1 waits for x1 retirement.
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
    tick();
    chk("raw_first_valid", {31'b0, out_valid}, 32'd1);
    in_instr = 32'h00108133; in_pc = 32'h104;
    #1;
    chk("raw_stall0", {31'b0, in_ready}, 32'd0);
    tick();
    chk("raw_stall_drained", {31'b0, out_valid}, 32'd0);
    chk("raw_stall1", {31'b0, in_ready}, 32'd0);
    sav_dat = 32'hCAFE0001;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_dat = sav_dat;
    #1;
`ifdef ID_WB_BYPASS_EN
    chk("raw_wb_cycle_ready", {31'b0, in_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
`else
    chk("raw_wb_cycle_ready", {31'b0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("raw_after_wb_ready", {31'b0, in_ready}, 32'd1);
    tick();
`endif
    in_valid = 1'b0;
    chk("raw_dep_valid", {31'b0, out_valid}, 32'd1);
    chk("raw_dep_pc", out_pc, 32'h104);
    chk("raw_dep_op1", out_op1, sav_dat);
    chk("raw_dep_op2", out_op2, sav_dat);
    retire(5'd2, 32'h2222);

    // Back-pressure: output held for three cycles while a new input waits.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00700193; in_pc = 32'h200;
    tick();
    in_instr = 32'h123452B7; in_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_out_pc", out_pc, 32'h200);
      chk("bp_out_imm", out_imm, 32'd7);
      chk("bp_out_rd", {27'b0, out_rd}, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_pc", out_pc, 32'h204);
    retire(5'd3, 32'h3333);
    retire(5'd5, 32'h5555);

    // Flush kills ADDI x5 in the output register and releases busy[5].
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100293; in_pc = 32'h300;
    tick();
    chk("fl_loaded", {31'b0, out_valid}, 32'd1);
    flush = 1'b1; in_instr = 32'h00100313; in_pc = 32'h304;
    #1;
    chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_killed", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    in_instr = 32'h005283B3; in_pc = 32'h308;
    #1;
    chk("fl_busy_cleared", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("fl_next_pc", out_pc, 32'h308);
    chk("fl_next_rd", {27'b0, out_rd}, 32'd7);
    retire(5'd7, 32'h7777);

    // Illegal opcode with busy source fields does not stall.
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h400;
    tick();
    in_instr = 32'h0010807F; in_pc = 32'h404;
    #1;
    chk("ill_no_stall", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("ill_out_illegal", {31'b0, out_illegal}, 32'd1);
    chk("ill_out_wb_en", {31'b0, out_wb_en}, 32'd0);
    chk("ill_out_pc", out_pc, 32'h404);
    retire(5'd1, 32'h1111);

    // Mid-operation reset with a held output and a busy register.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h500;
    tick();
    in_instr = 32'h00108133;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Randomized traffic against the model.
    m_out  = '0;
    m_busy = '0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      if (issued_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_valid = 1'b1;
        wb_rd    = issued_q.pop_front();
      end else begin
        wb_valid = 1'b0;
        wb_rd    = 5'($urandom_range(0, 31));
      end
      wb_dat = $urandom;
      #1;
      d  = decode(in_instr);
      r1 = in_instr[19:15];
      r2 = in_instr[24:20];
      byp1 = 1'b0;
      byp2 = 1'b0;
`ifdef ID_WB_BYPASS_EN
      byp1 = wb_valid && wb_rd == r1 && r1 != 5'd0;
      byp2 = wb_valid && wb_rd == r2 && r2 != 5'd0;
`endif
      haz = (d.u1 && m_busy[r1] && !byp1) || (d.u2 && m_busy[r2] && !byp2);
      rdy = !haz && !flush && (!m_out.v || out_ready);
      chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, rdy});
      chk("rnd_rs_idx", {22'b0, rs1, rs2}, {22'b0, r1, r2});

      nb = m_busy;
      if (flush && m_out.v && m_out.wb) nb[m_out.rd] = 1'b0;
      if (!flush && m_out.v && out_ready && m_out.wb) issued_q.push_back(m_out.rd);
      if (wb_valid) nb[wb_rd] = 1'b0;
      if (in_valid && rdy) begin
        if (d.wb) nb[in_instr[11:7]] = 1'b1;
        m_out.v   = 1'b1;
        m_out.pc  = in_pc;
        m_out.op1 = byp1 ? wb_dat : rf[r1];
        m_out.op2 = byp2 ? wb_dat : rf[r2];
        m_out.imm = d.imm;
        m_out.rd  = in_instr[11:7];
        m_out.opc = in_instr[6:0];
        m_out.f3  = in_instr[14:12];
        m_out.f7b = in_instr[30];
        m_out.wb  = d.wb;
        m_out.ill = d.ill;
      end else if (flush || out_ready) begin
        m_out.v = 1'b0;
      end
      nb[0] = 1'b0;
      tick();
      m_busy = nb;
      chk_out(m_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
